// File: rtl/seq_bcd_display_driver_pkg.sv
// rtl/seq_bcd_display_driver_pkg.sv - shared types, widths and 7-segment table
// Purpose: FSM state type, datapath widths, segment patterns and the
//          double-dabble nibble adjust helper used by the BCD display driver.
// Ports:   none (package).
package seq_bcd_display_driver_pkg;

  localparam int VALUE_W      = 6;
  localparam int BCD_W        = 4;
  localparam int SHIFT_CYCLES = 6;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

  // Active-high {g,f,e,d,c,b,a} patterns, entry 9 first so SEG_TABLE[d] is digit d.
  localparam logic [9:0][6:0] SEG_TABLE = {
    7'b1101111,  // 9
    7'b1111111,  // 8
    7'b0000111,  // 7
    7'b1111101,  // 6
    7'b1101101,  // 5
    7'b1100110,  // 4
    7'b1001111,  // 3
    7'b1011011,  // 2
    7'b0000110,  // 1
    7'b0111111   // 0
  };

  localparam logic [6:0] SEG_BLANK = 7'b0000000;

  // A nibble >= 5 would exceed 9 after the next shift, so pre-add 3.
  function automatic logic [BCD_W-1:0] bcd_adjust(input logic [BCD_W-1:0] nib);
    return (nib >= BCD_W'(5)) ? nib + BCD_W'(3) : nib;
  endfunction

endpackage

// File: rtl/seq_bcd_display_driver_seg7_decode.sv
// rtl/seq_bcd_display_driver_seg7_decode.sv - combinational BCD nibble to 7-segment decoder
// Purpose: maps a BCD digit to an active-high segment pattern; blank or a
//          non-decimal nibble turns every segment off.
// Ports:   digit (in, 4) BCD digit; blank (in, 1) force all segments off;
//          seg (out, 7) active-high {g,f,e,d,c,b,a}.
module seq_bcd_display_driver_seg7_decode
  import seq_bcd_display_driver_pkg::*;
(
  input  logic [BCD_W-1:0] digit,
  input  logic             blank,
  output logic [6:0]       seg
);

  always_comb begin
    seg = SEG_BLANK;
    if (!blank && (digit <= BCD_W'(9))) begin
      seg = SEG_TABLE[digit];
    end
  end

endmodule

// File: rtl/seq_bcd_display_driver.sv
// rtl/seq_bcd_display_driver.sv - sequential double-dabble BCD converter and 2-digit 7-seg scanner
// Purpose: converts a 6-bit value to two BCD digits (one shift per cycle) and
//          drives a time-multiplexed two-digit display with tens blanking.
// Ports:   clk, reset (sync, active-high); value (in, 6); load (in, 1);
//          busy, done (out, 1); bcd_tens, bcd_ones (out, 4);
//          seg (out, 7) {g,f,e,d,c,b,a}; an (out, 2) an[0]=ones, an[1]=tens.
// Option:  SEQ_BCD_AUTO_LOAD_EN - also start a conversion whenever value
//          differs from the last converted value.
module seq_bcd_display_driver
  import seq_bcd_display_driver_pkg::*;
#(
  parameter int REFRESH_DIV    = 50000,
  parameter int SEG_ACTIVE_LOW = 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [VALUE_W-1:0] value,
  input  logic               load,
  output logic               busy,
  output logic               done,
  output logic [BCD_W-1:0]   bcd_tens,
  output logic [BCD_W-1:0]   bcd_ones,
  output logic [6:0]         seg,
  output logic [1:0]         an
);

  localparam int              CNT_W   = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(REFRESH_DIV - 1);
  localparam logic            SEG_INV = (SEG_ACTIVE_LOW != 0);

  state_e               state_q, state_d;
  logic [VALUE_W-1:0]   shreg_q, shreg_d;
  logic [2*BCD_W-1:0]   scratch_q, scratch_d;
  logic [2:0]           iter_q, iter_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic [BCD_W-1:0]     tens_q, tens_d;
  logic [BCD_W-1:0]     ones_q, ones_d;
  logic [CNT_W-1:0]     refresh_q, refresh_d;
  logic                 sel_q, sel_d;     // 0 = ones digit, 1 = tens digit
  logic [6:0]           seg_q, seg_d;
  logic [1:0]           an_q, an_d;

  logic                 start;
  logic [2*BCD_W-1:0]   adj;
  logic [2*BCD_W+VALUE_W-1:0] shifted;
  logic [BCD_W-1:0]     dec_digit;
  logic                 dec_blank;
  logic [6:0]           dec_seg;

`ifdef SEQ_BCD_AUTO_LOAD_EN
  logic [VALUE_W-1:0]   copy_q, copy_d;
  assign start = load || (value != copy_q);
`else
  assign start = load;
`endif

  assign dec_digit = sel_q ? tens_q : ones_q;
  assign dec_blank = sel_q && (tens_q == '0);

  seq_bcd_display_driver_seg7_decode u_decode (
    .digit (dec_digit),
    .blank (dec_blank),
    .seg   (dec_seg)
  );

  always_comb begin
    state_d   = state_q;
    shreg_d   = shreg_q;
    scratch_d = scratch_q;
    iter_d    = iter_q;
    tens_d    = tens_q;
    ones_d    = ones_q;
`ifdef SEQ_BCD_AUTO_LOAD_EN
    copy_d    = copy_q;
`endif
    // Status flags trail the state by one edge so busy covers edges N+1..N+7
    // and done lands together with the digit update.
    busy_d    = (state_q != IDLE);
    done_d    = (state_q == DONE);
    adj       = {bcd_adjust(scratch_q[2*BCD_W-1:BCD_W]), bcd_adjust(scratch_q[BCD_W-1:0])};
    shifted   = {adj, shreg_q} << 1;

    case (state_q)
      IDLE: begin
        if (start) begin
          shreg_d   = value;
          scratch_d = '0;
          iter_d    = '0;
          state_d   = SHIFT;
`ifdef SEQ_BCD_AUTO_LOAD_EN
          copy_d    = value;
`endif
        end
      end
      SHIFT: begin
        {scratch_d, shreg_d} = shifted;
        iter_d = iter_q + 3'd1;
        if (iter_q == 3'(SHIFT_CYCLES - 1)) begin
          state_d = DONE;
        end
      end
      DONE: begin
        tens_d  = scratch_q[2*BCD_W-1:BCD_W];
        ones_d  = scratch_q[BCD_W-1:0];
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Free-running scan, independent of the converter.
    if (refresh_q == CNT_MAX) begin
      refresh_d = '0;
      sel_d     = ~sel_q;
    end else begin
      refresh_d = refresh_q + CNT_W'(1);
      sel_d     = sel_q;
    end

    seg_d = SEG_INV ? ~dec_seg : dec_seg;
    an_d  = sel_q ? 2'b10 : 2'b01;
    if (SEG_INV) begin
      an_d = ~an_d;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      shreg_q   <= '0;
      scratch_q <= '0;
      iter_q    <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      tens_q    <= '0;
      ones_q    <= '0;
      refresh_q <= '0;
      sel_q     <= 1'b0;
      seg_q     <= SEG_INV ? ~SEG_TABLE[0] : SEG_TABLE[0];
      an_q      <= SEG_INV ? 2'b10 : 2'b01;
`ifdef SEQ_BCD_AUTO_LOAD_EN
      copy_q    <= '0;
`endif
    end else begin
      state_q   <= state_d;
      shreg_q   <= shreg_d;
      scratch_q <= scratch_d;
      iter_q    <= iter_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      tens_q    <= tens_d;
      ones_q    <= ones_d;
      refresh_q <= refresh_d;
      sel_q     <= sel_d;
      seg_q     <= seg_d;
      an_q      <= an_d;
`ifdef SEQ_BCD_AUTO_LOAD_EN
      copy_q    <= copy_d;
`endif
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign bcd_tens = tens_q;
  assign bcd_ones = ones_q;
  assign seg      = seg_q;
  assign an       = an_q;

endmodule

// File: tb/tb_seq_bcd_display_driver.sv
// tb/tb_seq_bcd_display_driver.sv - self-checking bench for seq_bcd_display_driver
module tb_seq_bcd_display_driver;

  localparam int RD = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [5:0] value = '0;
  logic       load = 1'b0;
  logic       busy, done;
  logic [3:0] bcd_tens, bcd_ones;
  logic [6:0] seg;
  logic [1:0] an;

  int checks = 0;
  int errors = 0;

  seq_bcd_display_driver #(.REFRESH_DIV(RD), .SEG_ACTIVE_LOW(1)) dut (
    .clk      (clk),
    .reset    (reset),
    .value    (value),
    .load     (load),
    .busy     (busy),
    .done     (done),
    .bcd_tens (bcd_tens),
    .bcd_ones (bcd_ones),
    .seg      (seg),
    .an       (an)
  );

  always #5 clk = ~clk;

  function automatic logic [6:0] pat(input int d);
    case (d)
      0: return 7'b0111111;
      1: return 7'b0000110;
      2: return 7'b1011011;
      3: return 7'b1001111;
      4: return 7'b1100110;
      5: return 7'b1101101;
      6: return 7'b1111101;
      7: return 7'b0000111;
      8: return 7'b1111111;
      9: return 7'b1101111;
      default: return 7'b0000000;
    endcase
  endfunction

  // Behavioural model: a conversion occupies edges N..N+7 of the block;
  // digits are value/10 and value%10; scan slot = (edges since reset / RD) % 2.
  bit         started = 0;
  int         m_k, m_age, m_val, m_copy, m_tens, m_ones;
  bit         m_inflight, m_busy, m_done;
  logic [6:0] m_seg;
  logic [1:0] m_an;

  always @(posedge clk) begin
    bit idle, st;
    int sel_pre;
    if (reset) begin
      started = 1;
      m_k = 0; m_age = 0; m_val = 0; m_copy = 0; m_tens = 0; m_ones = 0;
      m_inflight = 0; m_busy = 0; m_done = 0;
      m_seg = 7'b1000000; m_an = 2'b10;
    end else begin
      sel_pre = (m_k / RD) % 2;
      if (sel_pre == 0) begin
        m_seg = ~pat(m_ones); m_an = 2'b10;
      end else begin
        m_seg = (m_tens == 0) ? 7'b1111111 : ~pat(m_tens); m_an = 2'b01;
      end
      m_k++;
      idle   = !m_inflight;
      m_busy = m_inflight;
      m_done = m_inflight && (m_age == 6);
      if (m_done) begin
        m_tens = m_val / 10;
        m_ones = m_val % 10;
      end
      if (m_inflight) begin
        m_age++;
        if (m_age == 7) m_inflight = 0;
      end
`ifdef SEQ_BCD_AUTO_LOAD_EN
      st = idle && (load || (int'(value) != m_copy));
`else
      st = idle && load;
`endif
      if (st) begin
        m_inflight = 1; m_age = 0; m_val = int'(value); m_copy = int'(value);
      end
    end
  end

  always @(negedge clk) begin
    if (started) begin
      checks++;
      if ({busy, done, bcd_tens, bcd_ones, seg, an} !==
          {m_busy, m_done, 4'(m_tens), 4'(m_ones), m_seg, m_an}) begin
        errors++;
        $display("FAIL cycle_model t=%0t got busy=%b done=%b bcd=%0d/%0d seg=%b an=%b expected busy=%b done=%b bcd=%0d/%0d seg=%b an=%b",
                 $time, busy, done, bcd_tens, bcd_ones, seg, an,
                 m_busy, m_done, m_tens, m_ones, m_seg, m_an);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp_v);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1; value = '0; load = 1'b0;
    step(); step();
    reset = 1'b0;
  endtask

  task automatic convert(input int v);
    bit seen;
    value = 6'(v); load = 1'b1;
    step();
    load = 1'b0;
    seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      step();
      if (done) seen = 1;
    end
    check("conv_done_seen", 32'(seen), 32'd1);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int busy_cnt, done_at, done_cnt, t0, o0, t1, o1;
    int ones_ok, tens_ok, bad, run, runs_bad, runs_seen;
    bit first;
    logic [1:0] prev;

    // Reset state
    do_reset();
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    check("rst_digits", {24'd0, bcd_tens, bcd_ones}, 0);
    check("rst_an", 32'(an), 32'(2'b10));
    check("rst_seg", 32'(seg), 32'(7'b1000000));

    // Latency with value 55
    value = 6'd55; load = 1'b1;
    step();
    load = 1'b0;
    busy_cnt = 0; done_at = -1; done_cnt = 0;
    for (int i = 1; i <= 10; i++) begin
      step();
      if (busy) busy_cnt++;
      if (done) begin
        done_cnt++;
        if (done_at < 0) done_at = i;
        check("lat_tens", 32'(bcd_tens), 5);
        check("lat_ones", 32'(bcd_ones), 5);
      end
    end
    check("lat_busy_cycles", 32'(busy_cnt), 7);
    check("lat_done_cycle", 32'(done_at), 7);
    check("lat_done_count", 32'(done_cnt), 1);

    // Boundaries and full sweep
    convert(63);
    check("v63_tens", 32'(bcd_tens), 6);
    check("v63_ones", 32'(bcd_ones), 3);
    convert(0);
    check("v0_digits", {24'd0, bcd_tens, bcd_ones}, 0);
    for (int v = 0; v < 64; v++) begin
      convert(v);
      check("sweep_tens", 32'(bcd_tens), 32'(v / 10));
      check("sweep_ones", 32'(bcd_ones), 32'(v % 10));
    end

    // Load while busy is ignored
    do_reset();
    value = 6'd21; load = 1'b1;
    step();
    load = 1'b0;
    step(); step();
    value = 6'd8; load = 1'b1;
    step();
    load = 1'b0;
    done_cnt = 0;
    for (int i = 0; i < 8; i++) begin
      step();
      if (done) begin
        done_cnt++;
        check("busyload_tens", 32'(bcd_tens), 2);
        check("busyload_ones", 32'(bcd_ones), 1);
      end
    end
    check("busyload_done_count", 32'(done_cnt), 1);

    // Reset during SHIFT iteration 4
    do_reset();
    value = 6'd55; load = 1'b1;
    step();
    load = 1'b0;
    step(); step(); step();
    reset = 1'b1; value = '0;
    step();
    check("midrst_busy", 32'(busy), 0);
    check("midrst_done", 32'(done), 0);
    check("midrst_digits", {24'd0, bcd_tens, bcd_ones}, 0);
    check("midrst_an", 32'(an), 32'(2'b10));
    check("midrst_seg", 32'(seg), 32'(7'b1000000));
    reset = 1'b0;
    done_cnt = 0;
    for (int i = 0; i < 12; i++) begin
      step();
      if (done) done_cnt++;
    end
    check("midrst_no_done", 32'(done_cnt), 0);

    // Scan with digits 3/7
    do_reset();
    convert(37);
    step(); step();
    ones_ok = 0; tens_ok = 0; bad = 0; run = 1; runs_bad = 0; runs_seen = 0;
    first = 1; prev = an;
    for (int i = 0; i < 24; i++) begin
      step();
      if (an == prev) run++;
      else begin
        if (!first) begin
          runs_seen++;
          if (run != RD) runs_bad++;
        end
        first = 0; run = 1; prev = an;
      end
      if (an == 2'b10 && seg == 7'b1111000) ones_ok++;
      else if (an == 2'b01 && seg == 7'b0110000) tens_ok++;
      else bad++;
    end
    check("scan37_ones_slots", 32'(ones_ok > 0), 1);
    check("scan37_tens_slots", 32'(tens_ok > 0), 1);
    check("scan37_bad_slots", 32'(bad), 0);
    check("scan37_runs_seen", 32'(runs_seen >= 2), 1);
    check("scan37_run_len", 32'(runs_bad), 0);

    // Tens blanking with digits 0/5
    convert(5);
    step(); step();
    ones_ok = 0; tens_ok = 0; bad = 0;
    for (int i = 0; i < 16; i++) begin
      step();
      if (an == 2'b10 && seg == 7'b0010010) ones_ok++;
      else if (an == 2'b01 && seg == 7'b1111111) tens_ok++;
      else bad++;
    end
    check("blank_ones_slots", 32'(ones_ok > 0), 1);
    check("blank_tens_slots", 32'(tens_ok > 0), 1);
    check("blank_bad_slots", 32'(bad), 0);

`ifdef SEQ_BCD_AUTO_LOAD_EN
    // Auto-load: 0 -> 1 -> 1 -> 2 with load held low
    do_reset();
    done_cnt = 0; t0 = -1; o0 = -1; t1 = -1; o1 = -1;
    for (int i = 0; i < 46; i++) begin
      if (i < 10) value = 6'd0;
      else if (i < 34) value = 6'd1;
      else value = 6'd2;
      step();
      if (done) begin
        if (done_cnt == 0) begin t0 = int'(bcd_tens); o0 = int'(bcd_ones); end
        if (done_cnt == 1) begin t1 = int'(bcd_tens); o1 = int'(bcd_ones); end
        done_cnt++;
      end
    end
    for (int i = 0; i < 10; i++) begin
      step();
      if (done) done_cnt++;
    end
    check("auto_done_count", 32'(done_cnt), 2);
    check("auto_first", 32'(t0 * 10 + o0), 1);
    check("auto_second", 32'(t1 * 10 + o1), 2);
`endif

    // Randomized traffic checked by the model every cycle
    do_reset();
    for (int i = 0; i < 400; i++) begin
      value = 6'($urandom_range(0, 63));
      load  = ($urandom_range(0, 3) == 0);
      reset = ($urandom_range(0, 99) == 0);
      step();
    end
    reset = 1'b0; load = 1'b0;
    for (int i = 0; i < 12; i++) step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
